jtag_tap_ctrl: RTL and testbench

- IEEE 1149.1 TAP controller for the on-chip JTAG network.
- Decodes TMS into the 16-state TAP FSM and holds the instruction register (IR), the IDCODE register and the BYPASS register.
- Drives per-chain shift/capture/select strobes to downstream test data register (TDR) chains and muxes their serial outputs onto TDO.
- Sits between the chip pads (tck/tms/tdi/tdo) and the TDR/SIB network.

---
 rtl/jtag_pkg.sv | 53 +++++
 rtl/jtag_tap_fsm.sv | 57 +++++
 rtl/jtag_tap_ctrl.sv | 109 ++++++++++
 tb/tb_jtag_tap_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TAP: state encodings, the TAP state enum,
// the Capture-IR pattern and the fixed BYPASS opcode rule.
package jtag_pkg;

    localparam logic [3:0] ST_EXIT2_DR   = 4'h0;
    localparam logic [3:0] ST_EXIT1_DR   = 4'h1;
    localparam logic [3:0] ST_SHIFT_DR   = 4'h2;
    localparam logic [3:0] ST_PAUSE_DR   = 4'h3;
    localparam logic [3:0] ST_SELECT_IR  = 4'h4;
    localparam logic [3:0] ST_UPDATE_DR  = 4'h5;
    localparam logic [3:0] ST_CAPTURE_DR = 4'h6;
    localparam logic [3:0] ST_SELECT_DR  = 4'h7;
    localparam logic [3:0] ST_EXIT2_IR   = 4'h8;
    localparam logic [3:0] ST_EXIT1_IR   = 4'h9;
    localparam logic [3:0] ST_SHIFT_IR   = 4'hA;
    localparam logic [3:0] ST_PAUSE_IR   = 4'hB;
    localparam logic [3:0] ST_RTI        = 4'hC;
    localparam logic [3:0] ST_UPDATE_IR  = 4'hD;
    localparam logic [3:0] ST_CAPTURE_IR = 4'hE;
    localparam logic [3:0] ST_TLR        = 4'hF;

    typedef enum logic [3:0] {
        S_EXIT2_DR   = ST_EXIT2_DR,
        S_EXIT1_DR   = ST_EXIT1_DR,
        S_SHIFT_DR   = ST_SHIFT_DR,
        S_PAUSE_DR   = ST_PAUSE_DR,
        S_SELECT_IR  = ST_SELECT_IR,
        S_UPDATE_DR  = ST_UPDATE_DR,
        S_CAPTURE_DR = ST_CAPTURE_DR,
        S_SELECT_DR  = ST_SELECT_DR,
        S_EXIT2_IR   = ST_EXIT2_IR,
        S_EXIT1_IR   = ST_EXIT1_IR,
        S_SHIFT_IR   = ST_SHIFT_IR,
        S_PAUSE_IR   = ST_PAUSE_IR,
        S_RTI        = ST_RTI,
        S_UPDATE_IR  = ST_UPDATE_IR,
        S_CAPTURE_IR = ST_CAPTURE_IR,
        S_TLR        = ST_TLR
    } tap_state_t;

    localparam logic [1:0] CAPTURE_IR_PAT = 2'b01;

    // The all-ones opcode is always BYPASS, whatever else the IR decode says.
    function automatic logic is_bypass_op(input logic [31:0] op, input int width);
        logic all_ones;
        all_ones = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i < width) all_ones = all_ones & op[i];
        end
        return all_ones;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine with the state decodes used by the
// instruction and data register paths.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic tck,
    input  logic trstb,
    input  logic tms,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr,
    output logic capture_ir,
    output logic shift_ir,
    output logic update_ir,
    output logic tlr
);

    tap_state_t state;
    tap_state_t state_nxt;

    always_ff @(posedge tck or negedge trstb) begin
        if (!trstb) state <= S_TLR;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_TLR:        state_nxt = tms ? S_TLR        : S_RTI;
            S_RTI:        state_nxt = tms ? S_SELECT_DR  : S_RTI;
            S_SELECT_DR:  state_nxt = tms ? S_SELECT_IR  : S_CAPTURE_DR;
            S_CAPTURE_DR: state_nxt = tms ? S_EXIT1_DR   : S_SHIFT_DR;
            S_SHIFT_DR:   state_nxt = tms ? S_EXIT1_DR   : S_SHIFT_DR;
            S_EXIT1_DR:   state_nxt = tms ? S_UPDATE_DR  : S_PAUSE_DR;
            S_PAUSE_DR:   state_nxt = tms ? S_EXIT2_DR   : S_PAUSE_DR;
            S_EXIT2_DR:   state_nxt = tms ? S_UPDATE_DR  : S_SHIFT_DR;
            S_UPDATE_DR:  state_nxt = tms ? S_SELECT_DR  : S_RTI;
            S_SELECT_IR:  state_nxt = tms ? S_TLR        : S_CAPTURE_IR;
            S_CAPTURE_IR: state_nxt = tms ? S_EXIT1_IR   : S_SHIFT_IR;
            S_SHIFT_IR:   state_nxt = tms ? S_EXIT1_IR   : S_SHIFT_IR;
            S_EXIT1_IR:   state_nxt = tms ? S_UPDATE_IR  : S_PAUSE_IR;
            S_PAUSE_IR:   state_nxt = tms ? S_EXIT2_IR   : S_PAUSE_IR;
            S_EXIT2_IR:   state_nxt = tms ? S_UPDATE_IR  : S_SHIFT_IR;
            S_UPDATE_IR:  state_nxt = tms ? S_SELECT_DR  : S_RTI;
            default:      state_nxt = S_TLR;
        endcase
    end

    assign capture_dr = (state == S_CAPTURE_DR);
    assign shift_dr   = (state == S_SHIFT_DR);
    assign update_dr  = (state == S_UPDATE_DR);
    assign capture_ir = (state == S_CAPTURE_IR);
    assign shift_ir   = (state == S_SHIFT_IR);
    assign update_ir  = (state == S_UPDATE_IR);
    assign tlr        = (state == S_TLR);

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: IR, IDCODE and BYPASS registers, per-chain TDR strobes
// and the negedge TDO mux between the pads and the TDR network.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int                  IR_WIDTH       = 4,
    parameter int                  N_TDR          = 2,
    parameter logic [31:0]         IDCODE_VALUE   = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0] INSTR_IDCODE   = IR_WIDTH'(4'h1),
    parameter logic [IR_WIDTH-1:0] INSTR_TDR_BASE = IR_WIDTH'(4'h2)
) (
    input  logic                tck,
    input  logic                trstb,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    output logic                tdr_si,
    input  logic [N_TDR-1:0]    tdr_so,
    output logic [N_TDR-1:0]    tdr_select,
    output logic [N_TDR-1:0]    tdr_shift,
    output logic [N_TDR-1:0]    tdr_capture,
    output logic                tlr,
    output logic [IR_WIDTH-1:0] ir_value
);

    logic                capture_dr, shift_dr, update_dr;
    logic                capture_ir, shift_ir, update_ir;
    logic [IR_WIDTH-1:0] ir_sr;
    logic [IR_WIDTH-1:0] ir_q;
    logic [31:0]         idcode_sr;
    logic                bypass_q;
    logic                bypass_op;
    logic                sel_idcode;
    logic                dr_out;

    jtag_tap_fsm u_fsm (
        .tck        (tck),
        .trstb      (trstb),
        .tms        (tms),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .tlr        (tlr)
    );

    assign tdr_si = tdi;

    // Test-Logic-Reset overrides the held IR straight away, not one clock later.
    assign ir_value = tlr ? INSTR_IDCODE : ir_q;

    always_ff @(posedge tck or negedge trstb) begin
        if (!trstb) begin
            ir_sr <= '0;
            ir_q  <= INSTR_IDCODE;
        end else begin
            if (capture_ir)    ir_sr <= IR_WIDTH'(CAPTURE_IR_PAT);
            else if (shift_ir) ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};

            if (tlr)            ir_q <= INSTR_IDCODE;
            else if (update_ir) ir_q <= ir_sr;
        end
    end

    always_ff @(posedge tck or negedge trstb) begin
        if (!trstb) begin
            idcode_sr <= '0;
            bypass_q  <= 1'b0;
        end else if (capture_dr) begin
            idcode_sr <= IDCODE_VALUE;
            bypass_q  <= 1'b0;
        end else if (shift_dr) begin
            idcode_sr <= {tdi, idcode_sr[31:1]};
            bypass_q  <= tdi;
        end
    end

    always_comb begin
        bypass_op  = is_bypass_op(32'(ir_value), IR_WIDTH);
        sel_idcode = !bypass_op && (ir_value == INSTR_IDCODE);
        tdr_select = '0;
        for (int i = 0; i < N_TDR; i++) begin
            if (!bypass_op && !sel_idcode && (ir_value == INSTR_TDR_BASE + IR_WIDTH'(i)))
                tdr_select[i] = 1'b1;
        end
        tdr_shift   = tdr_select & {N_TDR{capture_dr | shift_dr}};
        tdr_capture = tdr_select & {N_TDR{capture_dr | update_dr}};

        if (sel_idcode)       dr_out = idcode_sr[0];
        else if (|tdr_select) dr_out = |(tdr_so & tdr_select);
        else                  dr_out = bypass_q;
    end

    // TDO launches on the falling edge so the next device samples it cleanly.
    always_ff @(negedge tck or negedge trstb) begin
        if (!trstb) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo_en <= shift_ir | shift_dr;
            if (shift_ir)      tdo <= ir_sr[0];
            else if (shift_dr) tdo <= dr_out;
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: TAP walks, IDCODE/BYPASS/IR scans,
// chain strobes and asynchronous reset during an IR shift.
module tb_jtag_tap_ctrl;
    import jtag_pkg::*;

    logic       tck = 1'b0;
    logic       trstb;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_en;
    logic       tdr_si;
    logic [1:0] tdr_so;
    logic [1:0] tdr_select;
    logic [1:0] tdr_shift;
    logic [1:0] tdr_capture;
    logic       tlr;
    logic [3:0] ir_value;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] path [16];
    int         plen [16];
    logic [3:0] code [16];
    logic [31:0] dout;
    logic        en_all;

    jtag_tap_ctrl dut (
        .tck         (tck),
        .trstb       (trstb),
        .tms         (tms),
        .tdi         (tdi),
        .tdo         (tdo),
        .tdo_en      (tdo_en),
        .tdr_si      (tdr_si),
        .tdr_so      (tdr_so),
        .tdr_select  (tdr_select),
        .tdr_shift   (tdr_shift),
        .tdr_capture (tdr_capture),
        .tlr         (tlr),
        .ir_value    (ir_value)
    );

    always #5 tck = ~tck;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tck);
        #1;
    endtask

    // Starts and ends in Run-Test/Idle; din is shifted LSB first.
    task automatic scan(input logic is_ir, input int n, input logic [31:0] din,
                        output logic [31:0] so, output logic en);
        so = '0;
        en = 1'b1;
        tick(1'b1, 1'b0);
        if (is_ir) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            @(negedge tck);
            #1;
            so[i] = tdo;
            en = en & tdo_en;
            tick(i == n - 1, din[i]);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        path[0]  = 8'b0000_0000; plen[0]  = 0; code[0]  = ST_TLR;
        path[1]  = 8'b0000_0000; plen[1]  = 1; code[1]  = ST_RTI;
        path[2]  = 8'b0000_0010; plen[2]  = 2; code[2]  = ST_SELECT_DR;
        path[3]  = 8'b0000_0010; plen[3]  = 3; code[3]  = ST_CAPTURE_DR;
        path[4]  = 8'b0000_0010; plen[4]  = 4; code[4]  = ST_SHIFT_DR;
        path[5]  = 8'b0000_1010; plen[5]  = 4; code[5]  = ST_EXIT1_DR;
        path[6]  = 8'b0000_1010; plen[6]  = 5; code[6]  = ST_PAUSE_DR;
        path[7]  = 8'b0010_1010; plen[7]  = 6; code[7]  = ST_EXIT2_DR;
        path[8]  = 8'b0001_1010; plen[8]  = 5; code[8]  = ST_UPDATE_DR;
        path[9]  = 8'b0000_0110; plen[9]  = 3; code[9]  = ST_SELECT_IR;
        path[10] = 8'b0000_0110; plen[10] = 4; code[10] = ST_CAPTURE_IR;
        path[11] = 8'b0000_0110; plen[11] = 5; code[11] = ST_SHIFT_IR;
        path[12] = 8'b0001_0110; plen[12] = 5; code[12] = ST_EXIT1_IR;
        path[13] = 8'b0001_0110; plen[13] = 6; code[13] = ST_PAUSE_IR;
        path[14] = 8'b0101_0110; plen[14] = 7; code[14] = ST_EXIT2_IR;
        path[15] = 8'b0011_0110; plen[15] = 6; code[15] = ST_UPDATE_IR;

        trstb  = 1'b0;
        tms    = 1'b1;
        tdi    = 1'b0;
        tdr_so = 2'b00;
        repeat (2) @(posedge tck);
        #1;
        expect_eq("rst_tlr", tlr, 1'b1);
        expect_eq("rst_ir", ir_value, 4'h1);
        expect_eq("rst_tdo", tdo, 1'b0);
        expect_eq("rst_tdo_en", tdo_en, 1'b0);
        expect_eq("rst_sel", tdr_select, 2'b00);
        expect_eq("rst_shift", tdr_shift, 2'b00);
        expect_eq("rst_capture", tdr_capture, 2'b00);
        trstb = 1'b1;

        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < plen[k]; j++) tick(path[k][j], 1'b0);
            expect_eq($sformatf("walk_state%0d", k), dut.u_fsm.state, code[k]);
            expect_eq($sformatf("walk_tlr%0d", k), tlr, code[k] == ST_TLR);
            repeat (5) tick(1'b1, 1'b0);
            expect_eq($sformatf("tms5_state%0d", k), dut.u_fsm.state, ST_TLR);
            expect_eq($sformatf("tms5_tlr%0d", k), tlr, 1'b1);
            expect_eq($sformatf("tms5_ir%0d", k), ir_value, 4'h1);
        end

        tdi = 1'b1;
        #1;
        expect_eq("tdr_si", tdr_si, 1'b1);

        tick(1'b0, 1'b0);
        scan(1'b0, 32, 32'h0, dout, en_all);
        expect_eq("idcode", dout, 32'h1000_0001);
        expect_eq("idcode_en", en_all, 1'b1);
        @(negedge tck);
        #1;
        expect_eq("idle_tdo_en", tdo_en, 1'b0);

        scan(1'b1, 4, 32'hF, dout, en_all);
        expect_eq("ir_cap_F", dout[1:0], 2'b01);
        expect_eq("ir_en_F", en_all, 1'b1);
        expect_eq("ir_F", ir_value, 4'hF);
        scan(1'b0, 5, 32'b01101, dout, en_all);
        expect_eq("bypass_F", dout[4:0], 5'b11010);

        scan(1'b1, 4, 32'h9, dout, en_all);
        expect_eq("ir_9", ir_value, 4'h9);
        expect_eq("sel_9", tdr_select, 2'b00);
        scan(1'b0, 5, 32'b01101, dout, en_all);
        expect_eq("bypass_9", dout[4:0], 5'b11010);

        scan(1'b1, 4, 32'h0, dout, en_all);
        expect_eq("ir_cap_0", dout[3:0], 4'b0001);
        expect_eq("ir_0", ir_value, 4'h0);

        scan(1'b1, 4, 32'h3, dout, en_all);
        expect_eq("sel_3", tdr_select, 2'b10);

        scan(1'b1, 4, 32'h2, dout, en_all);
        expect_eq("sel_2", tdr_select, 2'b01);
        tdr_so = 2'b01;
        tick(1'b1, 1'b0);
        expect_eq("seldr_shift", tdr_shift, 2'b00);
        expect_eq("seldr_capture", tdr_capture, 2'b00);
        tick(1'b0, 1'b0);
        expect_eq("capdr_shift", tdr_shift, 2'b01);
        expect_eq("capdr_capture", tdr_capture, 2'b01);
        tick(1'b0, 1'b0);
        expect_eq("shdr_shift", tdr_shift, 2'b01);
        expect_eq("shdr_capture", tdr_capture, 2'b00);
        @(negedge tck);
        #1;
        expect_eq("chain_tdo_a", tdo, 1'b1);
        tdr_so = 2'b10;
        tick(1'b0, 1'b0);
        @(negedge tck);
        #1;
        expect_eq("chain_tdo_b", tdo, 1'b0);
        tdr_so = 2'b11;
        tick(1'b0, 1'b0);
        @(negedge tck);
        #1;
        expect_eq("chain_tdo_c", tdo, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        expect_eq("upddr_shift", tdr_shift, 2'b00);
        expect_eq("upddr_capture", tdr_capture, 2'b01);
        tick(1'b0, 1'b0);
        expect_eq("rti_capture", tdr_capture, 2'b00);

        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        expect_eq("pre_rst_en", tdo_en, 1'b1);
        #2;
        trstb = 1'b0;
        #1;
        expect_eq("midrst_ir", ir_value, 4'h1);
        expect_eq("midrst_tdo_en", tdo_en, 1'b0);
        expect_eq("midrst_tlr", tlr, 1'b1);
        expect_eq("midrst_sel", tdr_select, 2'b00);
        @(negedge tck);
        trstb = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        expect_eq("postrst_ir", ir_value, 4'h1);
        expect_eq("postrst_sel", tdr_select, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
